// File: rtl/otter_pkg.sv
// Shared OTTER types: RV32I major opcodes and control-unit state encoding.
package otter_pkg;

   typedef enum logic [6:0] {
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      BRANCH = 7'b1100011,
      OP     = 7'b0110011,
      OP_IMM = 7'b0010011,
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      WB    = 3'd3,
      TRAP  = 3'd4
   } cu_state_t;

   localparam int CNT_W = 4;

   function automatic logic intr_pending(input logic intr, input logic mie);
      return intr & mie;
   endfunction

endpackage

// File: rtl/otter_wait_cnt.sv
// Saturating wait-state counter with synchronous clear; o_done flags count == i_term.
module otter_wait_cnt
   import otter_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_term,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_done = (r_cnt == i_term);

endmodule

// File: rtl/otter_cu_fsm_intr.sv
// OTTER multicycle control FSM with fetch/load wait states, MIE-gated trap entry and MRET.
// Outputs are Moore from state, except EXEC which also decodes opcode/funct3.
module otter_cu_fsm_intr
   import otter_pkg::*;
#(
   parameter int FETCH_WAIT = 1,
   parameter int LOAD_WAIT  = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [6:0] i_ir_opcode,
   input  logic [2:0] i_ir_funct,
   input  logic       i_intr,
   input  logic       i_mie,
   output logic       o_pc_rst,
   output logic       o_pc_write,
   output logic       o_reg_write,
   output logic       o_mem_rden1,
   output logic       o_mem_rden2,
   output logic       o_mem_we2,
   output logic       o_csr_we,
   output logic       o_int_taken,
   output logic       o_mret_exec,
   output logic [2:0] o_state
);

   if (FETCH_WAIT < 1 || FETCH_WAIT > 15) begin : g_bad_fetch_wait
      $error("otter_cu_fsm_intr: FETCH_WAIT must be in 1..15");
   end
   if (LOAD_WAIT < 1 || LOAD_WAIT > 15) begin : g_bad_load_wait
      $error("otter_cu_fsm_intr: LOAD_WAIT must be in 1..15");
   end

   localparam logic [CNT_W-1:0] FW_TERM = CNT_W'(FETCH_WAIT - 1);
   localparam logic [CNT_W-1:0] LW_TERM = CNT_W'(LOAD_WAIT - 1);

   cu_state_t        r_state;
   cu_state_t        w_next;
   logic             w_done;
   logic             w_clr;
   logic             w_trap;
   logic [CNT_W-1:0] w_term;

   assign w_trap = intr_pending(i_intr, i_mie);
   assign w_term = (r_state == WB) ? LW_TERM : FW_TERM;
   // Any state change restarts the count, so FETCH and WB both begin at zero.
   assign w_clr  = (w_next != r_state);

   otter_wait_cnt #(.W(CNT_W)) u_wait_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_clr),
      .i_inc   (1'b1),
      .i_term  (w_term),
      .o_done  (w_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= INIT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      o_pc_rst    = 1'b0;
      o_pc_write  = 1'b0;
      o_reg_write = 1'b0;
      o_mem_rden1 = 1'b0;
      o_mem_rden2 = 1'b0;
      o_mem_we2   = 1'b0;
      o_csr_we    = 1'b0;
      o_int_taken = 1'b0;
      o_mret_exec = 1'b0;
      case (r_state)
         INIT: begin
            o_pc_rst = 1'b1;
            w_next   = FETCH;
         end
         FETCH: begin
            o_mem_rden1 = 1'b1;
            if (w_done) w_next = EXEC;
         end
         EXEC: begin
            o_pc_write = 1'b1;
            w_next     = w_trap ? TRAP : FETCH;
            case (i_ir_opcode)
               LOAD: begin
                  o_pc_write  = 1'b0;
                  o_mem_rden2 = 1'b1;
                  w_next      = WB;
               end
               STORE:  o_mem_we2 = 1'b1;
               BRANCH: ;
               OP, OP_IMM, LUI, AUIPC, JAL, JALR: o_reg_write = 1'b1;
               SYSTEM: begin
                  if (i_ir_funct != 3'b000) begin
                     o_csr_we    = 1'b1;
                     o_reg_write = 1'b1;
                  end else begin
                     o_mret_exec = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         WB: begin
            o_mem_rden2 = 1'b1;
            // Interrupts are only considered once the load has fully written back.
            if (w_done) begin
               o_reg_write = 1'b1;
               o_pc_write  = 1'b1;
               w_next      = w_trap ? TRAP : FETCH;
            end
         end
         TRAP: begin
            o_int_taken = 1'b1;
            o_pc_write  = 1'b1;
            w_next      = FETCH;
         end
         default: w_next = INIT;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: tb/tb_otter_cu_fsm_intr.sv
// Bench for otter_cu_fsm_intr: two instances (FETCH_WAIT/LOAD_WAIT 1/1 and 3/2) checked
// cycle by cycle against an instruction-timeline model built from the latency rules.
module tb_otter_cu_fsm_intr;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [6:0] op;
   logic [2:0] f3;
   logic       intr, mie;
   logic [8:0] a_o, b_o;
   logic [2:0] a_st, b_st;

   int total = 0;
   int bad   = 0;

   localparam logic [8:0] B_PCRST = 9'h100, B_PCW = 9'h080, B_RW  = 9'h040,
                          B_R1    = 9'h020, B_R2  = 9'h010, B_WE2 = 9'h008,
                          B_CSR   = 9'h004, B_IT  = 9'h002, B_MRET = 9'h001;
   localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                          S_WB = 3'd3, S_TRAP = 3'd4;
   localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                          OPC_ADDI = 7'b0010011, OPC_SYS = 7'b1110011;

   logic [6:0] ops [12] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                            7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                            7'b1100111, 7'b1110011, 7'b0001111, 7'b1111111};

   always #5 clk = ~clk;

   otter_cu_fsm_intr #(.FETCH_WAIT(3), .LOAD_WAIT(2)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_a), .i_ir_opcode(op), .i_ir_funct(f3),
      .i_intr(intr), .i_mie(mie),
      .o_pc_rst(a_o[8]), .o_pc_write(a_o[7]), .o_reg_write(a_o[6]),
      .o_mem_rden1(a_o[5]), .o_mem_rden2(a_o[4]), .o_mem_we2(a_o[3]),
      .o_csr_we(a_o[2]), .o_int_taken(a_o[1]), .o_mret_exec(a_o[0]),
      .o_state(a_st)
   );

   otter_cu_fsm_intr #(.FETCH_WAIT(1), .LOAD_WAIT(1)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_b), .i_ir_opcode(op), .i_ir_funct(f3),
      .i_intr(intr), .i_mie(mie),
      .o_pc_rst(b_o[8]), .o_pc_write(b_o[7]), .o_reg_write(b_o[6]),
      .o_mem_rden1(b_o[5]), .o_mem_rden2(b_o[4]), .o_mem_we2(b_o[3]),
      .o_csr_we(b_o[2]), .o_int_taken(b_o[1]), .o_mret_exec(b_o[0]),
      .o_state(b_st)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] got_v(input bit sel);
      return sel ? {b_st, b_o} : {a_st, a_o};
   endfunction

   // Write enables an instruction raises in its execute cycle.
   function automatic logic [8:0] exec_out(input logic [6:0] o, input logic [2:0] fn);
      case (o)
         7'b0000011: return B_R2;
         7'b0100011: return B_WE2 | B_PCW;
         7'b1100011: return B_PCW;
         7'b0110011, 7'b0010011, 7'b0110111,
         7'b0010111, 7'b1101111, 7'b1100111: return B_RW | B_PCW;
         7'b1110011: return (fn != 3'b000) ? (B_CSR | B_RW | B_PCW) : (B_MRET | B_PCW);
         default:    return B_PCW;
      endcase
   endfunction

   // One instruction starting in its first fetch cycle (called just after a rising edge).
   // Cycles: fw fetch, 1 exec, lw writeback for loads, then a trap cycle if INTR&&MIE
   // was high on the completing cycle.
   task automatic run_instr(input int fw, input int lw, input bit sel,
                            input logic [6:0] o, input logic [2:0] fn,
                            input bit rnd, input int rise, input bit fm, input string tag);
      bit          is_load = (o == OPC_LOAD);
      int          n       = is_load ? fw + 1 + lw : fw + 1;
      bit          trap    = 1'b0;
      logic [11:0] exp;
      op = o;
      f3 = fn;
      for (int c = 0; c < n; c++) begin
         if (rnd) begin
            intr = 1'($urandom_range(0, 1));
            mie  = 1'($urandom_range(0, 1));
         end else begin
            intr = (c >= rise);
            mie  = fm;
         end
         @(negedge clk);
         if (c < fw)       exp = {S_FETCH, B_R1};
         else if (c == fw) exp = {S_EXEC, exec_out(o, fn)};
         else              exp = {S_WB, B_R2 | ((c == n - 1) ? (B_RW | B_PCW) : 9'h000)};
         check_val(tag, {20'h0, got_v(sel)}, {20'h0, exp});
         if (c == n - 1) trap = intr && mie;
         @(posedge clk);
         #1;
      end
      if (trap) begin
         intr = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_val({tag, "_trap"}, {20'h0, got_v(sel)}, {20'h0, S_TRAP, B_IT | B_PCW});
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [11:0] rst_vec;
      rst_vec = {S_INIT, B_PCRST};
      rst_a = 1'b0; rst_b = 1'b0;
      op = '0; f3 = '0; intr = 1'b0; mie = 1'b0;

      repeat (2) @(negedge clk);
      intr = 1'b1; mie = 1'b1; op = OPC_STORE;
      #1;
      check_val("rst_a", {20'h0, got_v(0)}, {20'h0, rst_vec});
      check_val("rst_b", {20'h0, got_v(1)}, {20'h0, rst_vec});
      @(posedge clk); #1;
      check_val("rst_hold", {20'h0, got_v(0)}, {20'h0, rst_vec});

      // Instance B: FETCH_WAIT=1, LOAD_WAIT=1
      @(negedge clk);
      rst_b = 1'b1; intr = 1'b0;
      #1;
      check_val("b_init", {20'h0, got_v(1)}, {20'h0, rst_vec});
      @(posedge clk); #1;
      run_instr(1, 1, 1, OPC_ADDI, 3'd0, 0, 99, 0, "b_addi");
      run_instr(1, 1, 1, OPC_ADDI, 3'd0, 0, 99, 0, "b_addi2");
      run_instr(1, 1, 1, OPC_LOAD, 3'd2, 0, 0, 1, "b_load_trap");
      for (int i = 0; i < 40; i++)
         run_instr(1, 1, 1, ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                   1, 0, 0, "b_rand");
      #2 rst_b = 1'b0;

      // Instance A: FETCH_WAIT=3, LOAD_WAIT=2
      @(negedge clk);
      rst_a = 1'b1; intr = 1'b0;
      #1;
      check_val("a_init", {20'h0, got_v(0)}, {20'h0, rst_vec});
      @(posedge clk); #1;
      run_instr(3, 2, 0, OPC_LOAD,  3'd2, 0, 99, 0, "a_load");
      run_instr(3, 2, 0, OPC_STORE, 3'd2, 0, 0,  0, "a_sw_mie0");
      run_instr(3, 2, 0, OPC_STORE, 3'd2, 0, 0,  1, "a_sw_trap");
      run_instr(3, 2, 0, OPC_LOAD,  3'd2, 0, 4,  1, "a_ld_intr_wb");
      run_instr(3, 2, 0, OPC_SYS,   3'd1, 0, 99, 0, "a_csr");
      run_instr(3, 2, 0, OPC_SYS,   3'd0, 0, 99, 0, "a_mret");
      run_instr(3, 2, 0, OPC_SYS,   3'd0, 0, 0,  1, "a_mret_intr");
      run_instr(3, 2, 0, 7'b1111111, 3'd5, 0, 0, 1, "a_unknown");
      for (int i = 0; i < 50; i++)
         run_instr(3, 2, 0, ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                   1, 0, 0, "a_rand");

      // Async reset in the first WB cycle of a load
      op = OPC_LOAD; f3 = 3'd2; intr = 1'b0; mie = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check_val("a_mid_wb", {20'h0, got_v(0)}, {20'h0, S_WB, B_R2});
      rst_a = 1'b0;
      #1;
      check_val("a_async_rst", {20'h0, got_v(0)}, {20'h0, rst_vec});
      @(posedge clk); #1;
      check_val("a_rst_edge", {20'h0, got_v(0)}, {20'h0, rst_vec});
      @(negedge clk);
      rst_a = 1'b1;
      #1;
      check_val("a_rel", {20'h0, got_v(0)}, {20'h0, rst_vec});
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++)
         run_instr(3, 2, 0, ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                   1, 0, 0, "a_post_rst");
      check_val("b_parked", {20'h0, got_v(1)}, {20'h0, rst_vec});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
